// File: rtl/vram_arbiter_if.sv
// Memory-controller side of the VRAM arbiter: command pulses, address/data and the busy handshake.
interface vram_arbiter_if;
    logic        mc_read;
    logic        mc_write;
    logic        mc_refresh;
    logic [20:0] mc_addr;
    logic [15:0] mc_din;
    logic [1:0]  mc_wdm;
    logic [15:0] mc_dout;
    logic        mc_busy;

    modport master (
        output mc_read, mc_write, mc_refresh, mc_addr, mc_din, mc_wdm,
        input  mc_dout, mc_busy
    );

    modport slave (
        input  mc_read, mc_write, mc_refresh, mc_addr, mc_din, mc_wdm,
        output mc_dout, mc_busy
    );
endinterface

// File: rtl/vram_arbiter.sv
// Arbitrates VDP slots, an auxiliary port and DRAM refresh onto one memory controller.
// Define VRAM_ARB_AUX_EN to enable the auxiliary requester; otherwise aux_req is ignored.
module vram_arbiter #(
    parameter int unsigned REFRESH_MAX  = 8,
    parameter int unsigned BUSY_TIMEOUT = 63
) (
    input  logic                  clk_w,
    input  logic                  reset_n_w,
    input  logic                  vdp_slot,
    input  logic                  vdp_ref_slot,
    input  logic                  vdp_we_n,
    input  logic [16:0]           vdp_adr,
    input  logic [7:0]            vdp_dbo,
    output logic [15:0]           vdp_dbi,
    input  logic                  aux_req,
    input  logic                  aux_we,
    input  logic [16:0]           aux_adr,
    input  logic [7:0]            aux_dbo,
    output logic                  aux_ack,
    output logic [7:0]            aux_dbi,
    vram_arbiter_if.master        mc,
    output logic                  timeout
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} state_e;
    typedef enum logic [1:0] {SRC_VDP, SRC_AUX, SRC_REF} src_e;

    state_e      state_q;
    src_e        src_q;
    logic        we_q;
    logic [16:0] adr_q;
    logic [7:0]  dat_q;
    logic        served_q;
    logic [7:0]  ref_cnt_q;
    logic        ref_slot_q;
    logic [7:0]  wait_cnt_q;
    logic        timeout_q;
    logic [15:0] vdp_dbi_q;
    logic [7:0]  aux_dbi_q;
    logic        aux_ack_q;
    logic        mc_read_q;
    logic        mc_write_q;
    logic        mc_refresh_q;

    logic        aux_req_eff;
    logic        force_ref;
    logic        ref_rise;
    logic        sel_valid_d;
    src_e        sel_src_d;
    logic        issue_ref;

`ifdef VRAM_ARB_AUX_EN
    assign aux_req_eff = aux_req;
`else
    logic aux_req_unused;
    assign aux_req_unused = aux_req;
    assign aux_req_eff    = 1'b0;
`endif

    assign force_ref = (ref_cnt_q >= 8'(REFRESH_MAX));
    assign ref_rise  = vdp_ref_slot & ~ref_slot_q;

    // Fixed-priority pick, only meaningful in IDLE with the controller free.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        sel_valid_d = 1'b0;
        sel_src_d   = SRC_VDP;
        if (state_q == IDLE && !mc.mc_busy) begin
            if (vdp_slot && !served_q) begin
                sel_valid_d = 1'b1;
                sel_src_d   = SRC_VDP;
            end else if (force_ref) begin
                sel_valid_d = 1'b1;
                sel_src_d   = SRC_REF;
            end else if (aux_req_eff) begin
                sel_valid_d = 1'b1;
                sel_src_d   = SRC_AUX;
            end else if (vdp_ref_slot) begin
                sel_valid_d = 1'b1;
                sel_src_d   = SRC_REF;
            end
        end
    end

    assign issue_ref = sel_valid_d && (sel_src_d == SRC_REF);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            state_q      <= IDLE;
            src_q        <= SRC_VDP;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            served_q     <= 1'b0;
            ref_cnt_q    <= '0;
            ref_slot_q   <= 1'b0;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            vdp_dbi_q    <= '0;
            aux_dbi_q    <= '0;
            aux_ack_q    <= 1'b0;
            mc_read_q    <= 1'b0;
            mc_write_q   <= 1'b0;
            mc_refresh_q <= 1'b0;
        end else begin
            mc_read_q    <= 1'b0;
            mc_write_q   <= 1'b0;
            mc_refresh_q <= 1'b0;
            aux_ack_q    <= 1'b0;
            ref_slot_q   <= vdp_ref_slot;

            if (!vdp_slot) served_q <= 1'b0;

            if (issue_ref)                           ref_cnt_q <= '0;
            else if (ref_rise && ref_cnt_q != 8'hFF) ref_cnt_q <= ref_cnt_q + 8'd1;

            case (state_q)
                IDLE: begin
                    if (sel_valid_d) begin
                        state_q <= ISSUE;
                        src_q   <= sel_src_d;
                        case (sel_src_d)
                            SRC_VDP: begin
                                we_q       <= ~vdp_we_n;
                                adr_q      <= vdp_adr;
                                dat_q      <= vdp_dbo;
                                served_q   <= 1'b1;
                                mc_read_q  <= vdp_we_n;
                                mc_write_q <= ~vdp_we_n;
                            end
                            SRC_AUX: begin
                                we_q       <= aux_we;
                                adr_q      <= aux_adr;
                                dat_q      <= aux_dbo;
                                mc_read_q  <= ~aux_we;
                                mc_write_q <= aux_we;
                            end
                            default: begin
                                we_q         <= 1'b0;
                                mc_refresh_q <= 1'b1;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    state_q    <= WAIT_HI;
                    wait_cnt_q <= 8'd1;  // counts cycles since ISSUE
                end
                WAIT_HI, WAIT_LO: begin
                    if (state_q == WAIT_HI && mc.mc_busy) begin
                        state_q <= WAIT_LO;
                    end else if (state_q == WAIT_LO && !mc.mc_busy) begin
                        state_q <= DONE;
                        if (src_q == SRC_VDP && !we_q) vdp_dbi_q <= mc.mc_dout;
                        if (src_q == SRC_AUX) begin
                            aux_ack_q <= 1'b1;
                            if (!we_q) aux_dbi_q <= adr_q[16] ? mc.mc_dout[15:8] : mc.mc_dout[7:0];
                        end
                    end else if (wait_cnt_q >= 8'(BUSY_TIMEOUT)) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vdp_dbi       = vdp_dbi_q;
    assign aux_ack       = aux_ack_q;
    assign aux_dbi       = aux_dbi_q;
    assign timeout       = timeout_q;
    assign mc.mc_read    = mc_read_q;
    assign mc.mc_write   = mc_write_q;
    assign mc.mc_refresh = mc_refresh_q;
    assign mc.mc_addr    = {5'b0, adr_q[15:0]};
    assign mc.mc_din     = {dat_q, dat_q};
    assign mc.mc_wdm     = {~adr_q[16], adr_q[16]};

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter; aux scenarios follow the VRAM_ARB_AUX_EN build.
module tb_vram_arbiter;

    logic        clk_w = 1'b0;
    logic        reset_n_w;
    logic        vdp_slot, vdp_ref_slot, vdp_we_n;
    logic [16:0] vdp_adr;
    logic [7:0]  vdp_dbo;
    logic [15:0] vdp_dbi;
    logic        aux_req, aux_we;
    logic [16:0] aux_adr;
    logic [7:0]  aux_dbo;
    logic        aux_ack;
    logic [7:0]  aux_dbi;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_vdp_dbi;

    vram_arbiter_if mc_bus ();

    vram_arbiter dut (
        .clk_w        (clk_w),
        .reset_n_w    (reset_n_w),
        .vdp_slot     (vdp_slot),
        .vdp_ref_slot (vdp_ref_slot),
        .vdp_we_n     (vdp_we_n),
        .vdp_adr      (vdp_adr),
        .vdp_dbo      (vdp_dbo),
        .vdp_dbi      (vdp_dbi),
        .aux_req      (aux_req),
        .aux_we       (aux_we),
        .aux_adr      (aux_adr),
        .aux_dbo      (aux_dbo),
        .aux_ack      (aux_ack),
        .aux_dbi      (aux_dbi),
        .mc           (mc_bus),
        .timeout      (timeout)
    );

    always #5 clk_w = ~clk_w;

    function automatic logic [2:0] cmd_now();
        return {mc_bus.mc_read, mc_bus.mc_write, mc_bus.mc_refresh};
    endfunction

    task automatic step();
        @(posedge clk_w);
        #1;
    endtask

    task automatic drive_idle_inputs();
        vdp_slot       = 1'b0;
        vdp_ref_slot   = 1'b0;
        vdp_we_n       = 1'b1;
        vdp_adr        = '0;
        vdp_dbo        = '0;
        aux_req        = 1'b0;
        aux_we         = 1'b0;
        aux_adr        = '0;
        aux_dbo        = '0;
        mc_bus.mc_busy = 1'b0;
        mc_bus.mc_dout = '0;
    endtask

    task automatic apply_reset();
        drive_idle_inputs();
        reset_n_w = 1'b0;
        repeat (2) @(posedge clk_w);
        #1;
        reset_n_w = 1'b1;
        step();
        exp_vdp_dbi = 16'h0000;
    endtask

    // Acts as the memory controller for one transaction: finds the pulse (bounded), holds busy
    // high for hi cycles, returns at the DONE cycle with what was observed.
    task automatic serve(input int hi, input logic [15:0] dout,
                         output logic [2:0] cmd, output logic [20:0] addr, output logic [15:0] din,
                         output logic [1:0] wdm, output logic gone, output logic ack,
                         output logic [15:0] dbi_before);
        logic found = 1'b0;
        cmd = '0; addr = '0; din = '0; wdm = '0; gone = 1'b0; ack = 1'b0; dbi_before = '0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (cmd_now() != 3'b000) found = 1'b1;
            else step();
        end
        if (found) begin
            cmd  = cmd_now();
            addr = mc_bus.mc_addr;
            din  = mc_bus.mc_din;
            wdm  = mc_bus.mc_wdm;
            mc_bus.mc_busy = 1'b1;
            step();
            gone = (cmd_now() == 3'b000);
            repeat (hi - 1) step();
            mc_bus.mc_busy = 1'b0;
            mc_bus.mc_dout = dout;
            dbi_before     = vdp_dbi;
            step();
            ack = aux_ack;
        end
    endtask

    task automatic test_reset();
        drive_idle_inputs();
        reset_n_w = 1'b0;
        #3;
        n_checks++; if (cmd_now() !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", cmd_now()); end
        n_checks++; if (aux_ack !== 1'b0) begin n_fail++; $display("FAIL reset_aux_ack: got %b expected 0", aux_ack); end
        n_checks++; if (aux_dbi !== 8'h00) begin n_fail++; $display("FAIL reset_aux_dbi: got %h expected 00", aux_dbi); end
        n_checks++; if (vdp_dbi !== 16'h0000) begin n_fail++; $display("FAIL reset_vdp_dbi: got %h expected 0000", vdp_dbi); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        apply_reset();
    endtask

    task automatic test_vdp_read();
        logic [2:0] cmd; logic [20:0] addr; logic [15:0] din, dbi0; logic [1:0] wdm; logic gone, ack;
        int pulses = 0;
        vdp_slot = 1'b1; vdp_we_n = 1'b1; vdp_adr = 17'h1_0123; vdp_dbo = 8'h99;
        step();
        vdp_adr = 17'h0_1FFF;  // must not disturb the latched address
        serve(3, 16'hA55A, cmd, addr, din, wdm, gone, ack, dbi0);
        n_checks++; if (cmd !== 3'b100) begin n_fail++; $display("FAIL vdp_read_cmd: got %b expected 100", cmd); end
        n_checks++; if (addr !== 21'h00123) begin n_fail++; $display("FAIL vdp_read_addr: got %h expected 00123", addr); end
        n_checks++; if (wdm !== 2'b01) begin n_fail++; $display("FAIL vdp_read_wdm: got %b expected 01", wdm); end
        n_checks++; if (gone !== 1'b1) begin n_fail++; $display("FAIL vdp_read_pulse_len: got %b expected 1", gone); end
        n_checks++; if (dbi0 !== 16'h0000) begin n_fail++; $display("FAIL vdp_read_dbi_early: got %h expected 0000", dbi0); end
        n_checks++; if (vdp_dbi !== 16'hA55A) begin n_fail++; $display("FAIL vdp_read_dbi: got %h expected a55a", vdp_dbi); end
        n_checks++; if (mc_bus.mc_addr !== 21'h00123) begin n_fail++; $display("FAIL vdp_read_addr_hold: got %h expected 00123", mc_bus.mc_addr); end
        for (int i = 0; i < 6; i++) begin
            step();
            if (cmd_now() != 3'b000) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL vdp_served_once: got %0d pulses expected 0", pulses); end
        vdp_slot = 1'b0;
        step();
        exp_vdp_dbi = 16'hA55A;
    endtask

    task automatic test_vdp_write();
        logic [2:0] cmd; logic [20:0] addr; logic [15:0] din, dbi0; logic [1:0] wdm; logic gone, ack;
        vdp_slot = 1'b1; vdp_we_n = 1'b0; vdp_adr = 17'h0_0200; vdp_dbo = 8'h3C;
        step();
        serve(2, 16'hFFFF, cmd, addr, din, wdm, gone, ack, dbi0);
        n_checks++; if (cmd !== 3'b010) begin n_fail++; $display("FAIL vdp_write_cmd: got %b expected 010", cmd); end
        n_checks++; if (addr !== 21'h00200) begin n_fail++; $display("FAIL vdp_write_addr: got %h expected 00200", addr); end
        n_checks++; if (din !== 16'h3C3C) begin n_fail++; $display("FAIL vdp_write_din: got %h expected 3c3c", din); end
        n_checks++; if (wdm !== 2'b10) begin n_fail++; $display("FAIL vdp_write_wdm: got %b expected 10", wdm); end
        n_checks++; if (vdp_dbi !== exp_vdp_dbi) begin n_fail++; $display("FAIL vdp_write_dbi_hold: got %h expected %h", vdp_dbi, exp_vdp_dbi); end
        step();
        vdp_slot = 1'b0; vdp_we_n = 1'b1;
        step();
    endtask

`ifdef VRAM_ARB_AUX_EN
    task automatic test_aux_write();
        logic [2:0] cmd; logic [20:0] addr; logic [15:0] din, dbi0; logic [1:0] wdm; logic gone, ack;
        aux_req = 1'b1; aux_we = 1'b1; aux_adr = 17'h0_0040; aux_dbo = 8'h7E;
        step();
        serve(2, 16'h0000, cmd, addr, din, wdm, gone, ack, dbi0);
        aux_req = 1'b0;
        n_checks++; if (cmd !== 3'b010) begin n_fail++; $display("FAIL aux_write_cmd: got %b expected 010", cmd); end
        n_checks++; if (addr !== 21'h00040) begin n_fail++; $display("FAIL aux_write_addr: got %h expected 00040", addr); end
        n_checks++; if (din !== 16'h7E7E) begin n_fail++; $display("FAIL aux_write_din: got %h expected 7e7e", din); end
        n_checks++; if (wdm !== 2'b10) begin n_fail++; $display("FAIL aux_write_wdm: got %b expected 10", wdm); end
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL aux_write_ack: got %b expected 1", ack); end
        step();
        n_checks++; if (aux_ack !== 1'b0) begin n_fail++; $display("FAIL aux_write_ack_len: got %b expected 0", aux_ack); end
        step();
    endtask

    task automatic test_aux_read();
        logic [2:0] cmd; logic [20:0] addr; logic [15:0] din, dbi0; logic [1:0] wdm; logic gone, ack;
        logic [16:0] adr_tab [2] = '{17'h1_0050, 17'h0_0051};
        logic [7:0]  exp_tab [2] = '{8'hBE, 8'hEF};
        for (int i = 0; i < 2; i++) begin
            aux_req = 1'b1; aux_we = 1'b0; aux_adr = adr_tab[i];
            step();
            serve(2, 16'hBEEF, cmd, addr, din, wdm, gone, ack, dbi0);
            aux_req = 1'b0;
            n_checks++; if (cmd !== 3'b100) begin n_fail++; $display("FAIL aux_read%0d_cmd: got %b expected 100", i, cmd); end
            n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL aux_read%0d_ack: got %b expected 1", i, ack); end
            n_checks++; if (aux_dbi !== exp_tab[i]) begin n_fail++; $display("FAIL aux_read%0d_dbi: got %h expected %h", i, aux_dbi, exp_tab[i]); end
            step();
            step();
        end
    endtask

    task automatic test_contention();
        logic [2:0] cmd; logic [20:0] addr; logic [15:0] din, dbi0; logic [1:0] wdm; logic gone, ack;
        vdp_slot = 1'b1; vdp_we_n = 1'b1; vdp_adr = 17'h0_0300;
        aux_req  = 1'b1; aux_we   = 1'b0; aux_adr = 17'h0_0400;
        step();
        serve(2, 16'h1111, cmd, addr, din, wdm, gone, ack, dbi0);
        n_checks++; if (addr !== 21'h00300) begin n_fail++; $display("FAIL contention_first_addr: got %h expected 00300", addr); end
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL contention_first_ack: got %b expected 0", ack); end
        step();
        serve(2, 16'h2222, cmd, addr, din, wdm, gone, ack, dbi0);
        aux_req = 1'b0; vdp_slot = 1'b0;
        n_checks++; if (addr !== 21'h00400) begin n_fail++; $display("FAIL contention_second_addr: got %h expected 00400", addr); end
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL contention_second_ack: got %b expected 1", ack); end
        n_checks++; if (aux_dbi !== 8'h22) begin n_fail++; $display("FAIL contention_aux_dbi: got %h expected 22", aux_dbi); end
        step();
        n_checks++; if (aux_ack !== 1'b0) begin n_fail++; $display("FAIL contention_ack_once: got %b expected 0", aux_ack); end
        step();
        exp_vdp_dbi = 16'h1111;
    endtask

    task automatic test_forced_refresh_aux();
        logic [2:0] cmd; logic [20:0] addr; logic [15:0] din, dbi0; logic [1:0] wdm; logic gone, ack;
        int pulses = 0;
        apply_reset();
        aux_req = 1'b1; aux_we = 1'b1; aux_adr = 17'h0_0060; aux_dbo = 8'h11;
        for (int i = 0; i < 8; i++) begin
            vdp_ref_slot = 1'b1;
            step();
            vdp_ref_slot = 1'b0;
            serve(2, 16'h0000, cmd, addr, din, wdm, gone, ack, dbi0);
            n_checks++; if (cmd !== 3'b010) begin n_fail++; $display("FAIL aux_window%0d_cmd: got %b expected 010", i, cmd); end
            step();
        end
        serve(2, 16'h0000, cmd, addr, din, wdm, gone, ack, dbi0);
        n_checks++; if (cmd !== 3'b001) begin n_fail++; $display("FAIL aux_forced_ref_cmd: got %b expected 001", cmd); end
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL aux_forced_ref_ack: got %b expected 0", ack); end
        step();
        serve(2, 16'h0000, cmd, addr, din, wdm, gone, ack, dbi0);
        aux_req = 1'b0;
        n_checks++; if (cmd !== 3'b010) begin n_fail++; $display("FAIL aux_after_ref_cmd: got %b expected 010", cmd); end
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL aux_after_ref_ack: got %b expected 1", ack); end
        for (int i = 0; i < 5; i++) begin
            step();
            if (cmd_now() != 3'b000) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL aux_ref_cnt_cleared: got %0d pulses expected 0", pulses); end
    endtask
`else
    task automatic test_aux_ignored();
        int pulses = 0;
        int acks   = 0;
        aux_req = 1'b1; aux_we = 1'b1; aux_adr = 17'h0_0040; aux_dbo = 8'h7E;
        for (int i = 0; i < 8; i++) begin
            step();
            if (cmd_now() != 3'b000) pulses++;
            if (aux_ack !== 1'b0) acks++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL aux_ignored_pulses: got %0d expected 0", pulses); end
        n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL aux_ignored_ack: got %0d expected 0", acks); end
        n_checks++; if (aux_dbi !== 8'h00) begin n_fail++; $display("FAIL aux_ignored_dbi: got %h expected 00", aux_dbi); end
        aux_req = 1'b0;
        step();
    endtask
`endif

    task automatic test_forced_refresh();
        logic [2:0] cmd; logic [20:0] addr; logic [15:0] din, dbi0; logic [1:0] wdm; logic gone, ack;
        int pulses = 0;
        apply_reset();
        mc_bus.mc_busy = 1'b1;  // controller busy: windows pass with no refresh issued
        for (int i = 0; i < 8; i++) begin
            vdp_ref_slot = 1'b1;
            step();
            if (cmd_now() != 3'b000) pulses++;
            vdp_ref_slot = 1'b0;
            step();
            if (cmd_now() != 3'b000) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL busy_windows_pulses: got %0d expected 0", pulses); end
        vdp_slot = 1'b1; vdp_we_n = 1'b1; vdp_adr = 17'h0_0010;
        mc_bus.mc_busy = 1'b0;
        step();
        serve(2, 16'h1234, cmd, addr, din, wdm, gone, ack, dbi0);
        n_checks++; if (cmd !== 3'b100) begin n_fail++; $display("FAIL vdp_beats_ref_cmd: got %b expected 100", cmd); end
        n_checks++; if (addr !== 21'h00010) begin n_fail++; $display("FAIL vdp_beats_ref_addr: got %h expected 00010", addr); end
        step();
        serve(2, 16'h0000, cmd, addr, din, wdm, gone, ack, dbi0);
        vdp_slot = 1'b0;
        n_checks++; if (cmd !== 3'b001) begin n_fail++; $display("FAIL forced_ref_cmd: got %b expected 001", cmd); end
        n_checks++; if (vdp_dbi !== 16'h1234) begin n_fail++; $display("FAIL forced_ref_dbi_hold: got %h expected 1234", vdp_dbi); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (cmd_now() != 3'b000) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL ref_cnt_cleared: got %0d pulses expected 0", pulses); end
        exp_vdp_dbi = 16'h1234;
    endtask

    task automatic test_timeout();
        logic [2:0] cmd; logic [20:0] addr; logic [15:0] din, dbi0; logic [1:0] wdm; logic gone, ack;
        int acks = 0;
        vdp_slot = 1'b1; vdp_we_n = 1'b1; vdp_adr = 17'h0_0020;
        step();
        n_checks++; if (cmd_now() !== 3'b100) begin n_fail++; $display("FAIL timeout_issue: got %b expected 100", cmd_now()); end
        for (int i = 1; i < 64; i++) begin
            step();
            if (aux_ack !== 1'b0) acks++;
        end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0 at cycle 63", timeout); end
        step();
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b expected 1 at cycle 64", timeout); end
        n_checks++; if (acks !== 0 || aux_ack !== 1'b0) begin n_fail++; $display("FAIL timeout_no_ack: got %0d acks expected 0", acks); end
        n_checks++; if (vdp_dbi !== exp_vdp_dbi) begin n_fail++; $display("FAIL timeout_dbi_hold: got %h expected %h", vdp_dbi, exp_vdp_dbi); end
        vdp_slot = 1'b0;
        step();
        vdp_slot = 1'b1; vdp_adr = 17'h0_0030;
        serve(2, 16'h5678, cmd, addr, din, wdm, gone, ack, dbi0);
        n_checks++; if (addr !== 21'h00030) begin n_fail++; $display("FAIL after_timeout_addr: got %h expected 00030", addr); end
        n_checks++; if (vdp_dbi !== 16'h5678) begin n_fail++; $display("FAIL after_timeout_dbi: got %h expected 5678", vdp_dbi); end
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", timeout); end
        vdp_slot = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        int pulses = 0;
        int dbi_changes = 0;
        vdp_slot = 1'b1; vdp_we_n = 1'b1; vdp_adr = 17'h0_0040;
        step();
        mc_bus.mc_busy = 1'b1;
        step();
        step();
        reset_n_w = 1'b0;
        #1;
        n_checks++; if (vdp_dbi !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_dbi: got %h expected 0000", vdp_dbi); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL mid_reset_timeout: got %b expected 0", timeout); end
        n_checks++; if (cmd_now() !== 3'b000 || aux_ack !== 1'b0) begin n_fail++; $display("FAIL mid_reset_pulses: got %b/%b expected 000/0", cmd_now(), aux_ack); end
        @(posedge clk_w);
        #1;
        reset_n_w = 1'b1;
        vdp_slot = 1'b0;
        mc_bus.mc_busy = 1'b0;
        mc_bus.mc_dout = 16'hDEAD;
        for (int i = 0; i < 6; i++) begin
            step();
            if (aux_ack !== 1'b0) acks++;
            if (cmd_now() != 3'b000) pulses++;
            if (vdp_dbi !== 16'h0000) dbi_changes++;
        end
        n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL mid_reset_no_ack: got %0d expected 0", acks); end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL mid_reset_no_cmd: got %0d expected 0", pulses); end
        n_checks++; if (dbi_changes !== 0) begin n_fail++; $display("FAIL mid_reset_dropped: got %0d dbi updates expected 0", dbi_changes); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_vdp_dbi = 16'h0000;
        test_reset();
        test_vdp_read();
        test_vdp_write();
`ifdef VRAM_ARB_AUX_EN
        test_aux_write();
        test_aux_read();
        test_contention();
        test_forced_refresh_aux();
`else
        test_aux_ignored();
`endif
        test_forced_refresh();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_MAX, default 8: maximum consecutive idle windows without a refresh before refresh is forced (legal range 1..255).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 63: clk_w cycles to wait for mc_busy before aborting (legal range 1..255).
REQ-003 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk_w  in  1  clock; all ports are synchronous to it, and any CDC is outside this block.
- reset_n_w  in  1  reset, asynchronous, active-low.
- vdp_slot  in  1  VDP access window (DLClk&DHClk).
- vdp_ref_slot  in  1  VDP idle window (~DLClk&~DHClk).
- vdp_we_n  in  1  VDP write strobe, active-low.
- vdp_adr  in  17  VDP address; bit 16 selects the byte lane.
- vdp_dbo  in  8  VDP write data.
- vdp_dbi  out  16  VDP read data, registered.
- aux_req  in  1  auxiliary request, level; held until ack.
- aux_we  in  1  auxiliary write, 1=write.
- aux_adr  in  17  auxiliary address.
- aux_dbo  in  8  auxiliary write data.
- aux_ack  out  1  one-cycle completion pulse.
- aux_dbi  out  8  auxiliary read byte, valid with aux_ack.
- mc_read, mc_write, mc_refresh  out  1 each  one-cycle command pulses.
- mc_addr  out  21  {5'b0, adr[15:0]}.
- mc_din  out  16  {d, d}.
- mc_wdm  out  2  {~adr[16], adr[16]}.
- mc_dout  in  16  controller read data.
- mc_busy  in  1  controller busy.
- timeout  out  1  sticky error flag.

Function
REQ-004 SHALL use states IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE.
REQ-005 In IDLE with mc_busy=0, SHALL select the requester by fixed priority: vdp_slot, then forced refresh (ref_cnt>=REFRESH_MAX), then aux_req, then vdp_ref_slot (opportunistic refresh).
REQ-006 SHALL latch the command, address and data on IDLE->ISSUE; later input changes SHALL have no effect until DONE.
REQ-007 ISSUE SHALL assert exactly one mc_* pulse for one cycle, then go to WAIT_HI.
REQ-008 WAIT_HI SHALL go to WAIT_LO on mc_busy=1.
REQ-009 WAIT_LO SHALL go to DONE on mc_busy=0 and capture mc_dout for reads.
REQ-010 DONE SHALL return to IDLE after one cycle.
REQ-011 A VDP read SHALL update vdp_dbi in DONE; vdp_dbi SHALL hold otherwise.
REQ-012 An aux transaction SHALL pulse aux_ack in DONE; for reads, aux_dbi SHALL be mc_dout[15:8] if aux_adr[16]=1, else mc_dout[7:0].
REQ-013 The VDP SHALL be served at most once per vdp_slot assertion, via a served flag cleared when vdp_slot=0.
REQ-014 ref_cnt (8-bit) SHALL clear on a refresh and increment, saturating at 255, at each vdp_ref_slot rising edge with no refresh issued.
REQ-015 aux_req arriving while vdp_slot=1 SHALL wait; starvation is acceptable, with no reordering.
REQ-016 WAIT_HI/WAIT_LO lasting more than BUSY_TIMEOUT cycles SHALL set timeout and go to IDLE with no ack and no vdp_dbi update; timeout SHALL clear only on reset.
REQ-017 Simultaneous vdp_slot and forced refresh SHALL serve the VDP; the refresh is issued at the next eligible IDLE.
REQ-018 Minimum transaction length SHALL be 4 cycles (ISSUE, WAIT_HI, WAIT_LO, DONE) plus the IDLE decision cycle.

Reset
REQ-019 On reset_n_w=0 the block SHALL immediately enter IDLE, with all mc_* pulses, aux_ack, timeout, vdp_dbi, aux_dbi, ref_cnt and the served flag at 0.
REQ-020 Reset mid-transaction SHALL drop the transaction with no ack after release; the requester re-requests.

Configuration
REQ-021 Macro VRAM_ARB_AUX_EN defined: the aux port and arbitration are as specified.
REQ-022 Macro VRAM_ARB_AUX_EN undefined: aux_req is ignored and aux_ack=0, aux_dbi=0 constantly; the priority is VDP, forced refresh, opportunistic refresh.

Verification
REQ-023 VDP read: vdp_slot=1, vdp_we_n=1, vdp_adr=17'h1_0123, busy high 3 cycles, mc_dout=16'hA55A -> one mc_read, mc_addr=21'h00123, vdp_dbi=16'hA55A.
REQ-024 Aux write: aux_req=1, aux_we=1, aux_adr=17'h0_0040, aux_dbo=8'h7E, vdp_slot=0 -> mc_write, mc_din=16'h7E7E, mc_wdm=2'b10, one aux_ack.
REQ-025 Forced refresh: 8 vdp_ref_slot windows with aux_req held -> the aux transactions are followed by mc_refresh once ref_cnt=8, ahead of the pending aux; ref_cnt returns to 0.
REQ-026 Contention: aux_req and vdp_slot rise on the same cycle -> the VDP is issued first, then the aux; aux_ack occurs exactly once.
REQ-027 Timeout: mc_busy stuck 0 after ISSUE -> timeout=1 at cycle 64, state IDLE, no aux_ack.
REQ-028 Reset mid-WAIT_LO: reset_n_w low for 1 cycle -> all outputs 0, and no ack after release.
